// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, instruction class encodings and FSM states for pc_sequencer.
package pc_seq_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_OFF_W  = 8;
   localparam logic [2:0] OP_SEQ  = 3'd0;
   localparam logic [2:0] OP_BR   = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT} state_e;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO return-address stack; overflowing pushes and underflowing pops are dropped and pulsed.
module ret_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         ovf_o,
   output logic         udf_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]  sp_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         full;
   assign full    = sp_q == (AW+1)'(DEPTH);
   assign empty_o = sp_q == '0;
   assign ovf_o   = push_i & full;
   assign udf_o   = pop_i & empty_o;
   assign top_o   = mem_q[AW'(sp_q - 1'b1)];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !full) begin
         mem_q[sp_q[AW-1:0]] <= data_i;
         sp_q <= sp_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         sp_q <= sp_q - 1'b1;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute/update controller that computes the next PC and drives its load strobe.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int OFF_W       = DEF_OFF_W,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              PC_rst,
   input  logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] PC_next,
   output logic              PC_load,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   output logic              instr_valid,
   input  logic [2:0]        op,
   input  logic              br_taken,
   input  logic [OFF_W-1:0]  br_off,
   input  logic [ADDR_W-1:0] target,
   input  logic              exec_done,
   input  logic              run,
   output logic              halted,
   output logic              stack_err
);
   state_e            state_q;
   logic [2:0]        op_q;
   logic              br_taken_q;
   logic [OFF_W-1:0]  br_off_q;
   logic [ADDR_W-1:0] target_q;
   logic [ADDR_W-1:0] pc_next_q;
   logic              pc_load_q;
   logic              imem_req_q;
   logic              instr_valid_q;
   logic              halted_q;
   logic              stack_err_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] pc_next_d;
   logic [ADDR_W-1:0] st_top;
   logic              st_empty;
   logic              st_ovf;
   logic              st_udf;
   logic              push;
   logic              pop;
   assign pc_inc  = PC + ADDR_W'(1);
   assign off_ext = {{(ADDR_W-OFF_W){br_off_q[OFF_W-1]}}, br_off_q};
   // RET on an empty stack falls through to PC+1
   assign pc_next_d = (op_q == OP_BR && br_taken_q) ? pc_inc + off_ext :
                      (op_q == OP_JMP || op_q == OP_CALL) ? target_q :
                      (op_q == OP_RET && !st_empty) ? st_top : pc_inc;
   assign push = state_q == S_UPDATE && op_q == OP_CALL;
   assign pop  = state_q == S_UPDATE && op_q == OP_RET;
   ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
      .clk    (clk),
      .rst    (PC_rst),
      .push_i (push),
      .pop_i  (pop),
      .data_i (pc_inc),
      .top_o  (st_top),
      .empty_o(st_empty),
      .ovf_o  (st_ovf),
      .udf_o  (st_udf)
   );
   always_ff @(posedge clk or posedge PC_rst) begin
      if (PC_rst) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         br_taken_q    <= 1'b0;
         br_off_q      <= '0;
         target_q      <= '0;
         pc_next_q     <= '0;
         pc_load_q     <= 1'b0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         stack_err_q   <= 1'b0;
      end else begin
         pc_load_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         stack_err_q   <= stack_err_q | st_ovf | st_udf;
         case (state_q)
            S_IDLE: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
            end
            S_FETCH: if (imem_ack) begin
               state_q       <= S_DECODE;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b1;
            end
            S_DECODE: begin
               state_q    <= S_EXEC;
               op_q       <= op;
               br_taken_q <= br_taken;
               br_off_q   <= br_off;
               target_q   <= target;
            end
            S_EXEC: if (exec_done) begin
               state_q   <= op_q == OP_HALT ? S_HALT : S_UPDATE;
               halted_q  <= op_q == OP_HALT;
               pc_load_q <= op_q != OP_HALT;
               pc_next_q <= op_q == OP_HALT ? pc_next_q : pc_next_d;
            end
            S_UPDATE: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
            end
            S_HALT: if (run) begin
               state_q   <= S_UPDATE;
               halted_q  <= 1'b0;
               pc_load_q <= 1'b1;
               pc_next_q <= pc_inc;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign PC_next     = pc_next_q;
   assign PC_load     = pc_load_q;
   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_req_q ? PC : '0;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign stack_err   = stack_err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random instruction streams checked against a queue-based PC/stack model.
module tb_pc_sequencer;
   import pc_seq_pkg::*;
   logic        clk = 1'b0;
   logic        PC_rst = 1'b0;
   logic [15:0] pc = '0;
   logic [15:0] PC_next;
   logic        PC_load;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic        instr_valid;
   logic [2:0]  op = '0;
   logic        br_taken = 1'b0;
   logic [7:0]  br_off = '0;
   logic [15:0] target = '0;
   logic        exec_done = 1'b0;
   logic        run = 1'b0;
   logic        halted;
   logic        stack_err;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] stk[$];
   logic        err_m = 1'b0;

   pc_sequencer dut (
      .clk(clk), .PC_rst(PC_rst), .PC(pc), .PC_next(PC_next), .PC_load(PC_load),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .instr_valid(instr_valid),
      .op(op), .br_taken(br_taken), .br_off(br_off), .target(target), .exec_done(exec_done),
      .run(run), .halted(halted), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      PC_rst = 1'b1;
      #1;
      chk("rst_load", PC_load, 0);
      chk("rst_next", PC_next, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_ivalid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_err", stack_err, 0);
      stk.delete();
      err_m = 1'b0;
      @(negedge clk);
      PC_rst = 1'b0;
      #1;
      chk("idle_req", imem_req, 0);
      tick;
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, pc);
   endtask

   task automatic instr(input logic [2:0] o, input logic brt, input logic [7:0] off, input logic [15:0] tgt,
                        input int ad, input int ed, input int hold, input int abort);
      logic [15:0] exp;
      #1;
      chk("req", imem_req, 1);
      chk("addr", imem_addr, pc);
      for (int k = 0; k < ad; k++) begin
         imem_ack = 1'b0;
         exec_done = 1'($urandom);
         run = 1'($urandom);
         tick;
         chk("req_hold", imem_req, 1);
         chk("addr_hold", imem_addr, pc);
         chk("noload_fetch", PC_load, 0);
         if (abort == 2) begin
            do_reset;
            return;
         end
      end
      imem_ack = 1'b1;
      run = 1'b0;
      op = o; br_taken = brt; br_off = off; target = tgt;
      tick;
      imem_ack = 1'b0;
      chk("ivalid", instr_valid, 1);
      chk("req_dec", imem_req, 0);
      chk("addr_dec", imem_addr, 0);
      tick;
      op = 3'($urandom); br_taken = 1'($urandom); br_off = 8'($urandom); target = 16'($urandom);
      exec_done = 1'b0;
      chk("ivalid_off", instr_valid, 0);
      if (abort == 1) begin
         exec_done = 1'b1;
         do_reset;
         exec_done = 1'b0;
         return;
      end
      for (int k = 0; k < ed; k++) begin
         imem_ack = 1'($urandom);
         run = 1'($urandom);
         tick;
         chk("noload_exec", PC_load, 0);
      end
      imem_ack = 1'b0;
      run = 1'b0;
      exec_done = 1'b1;
      tick;
      exec_done = 1'b0;
      if (o == OP_HALT) begin
         chk("halted", halted, 1);
         chk("noload_halt", PC_load, 0);
         for (int k = 0; k < hold; k++) begin
            exec_done = 1'($urandom);
            imem_ack = 1'($urandom);
            tick;
            chk("halt_noload", PC_load, 0);
            chk("halt_hold", halted, 1);
         end
         exec_done = 1'b0;
         imem_ack = 1'b0;
         run = 1'b1;
         tick;
         run = 1'b0;
         exp = pc + 16'd1;
      end else begin
         case (o)
            OP_BR:   exp = brt ? 16'(int'(pc) + 1 + int'($signed(off))) : pc + 16'd1;
            OP_JMP:  exp = tgt;
            OP_CALL: begin
               if (stk.size() < 4) stk.push_back(pc + 16'd1);
               else err_m = 1'b1;
               exp = tgt;
            end
            OP_RET: begin
               if (stk.size() > 0) exp = stk.pop_back();
               else begin
                  err_m = 1'b1;
                  exp = pc + 16'd1;
               end
            end
            default: exp = pc + 16'd1;
         endcase
      end
      chk("load", PC_load, 1);
      chk("pc_next", PC_next, exp);
      chk("halted_off", halted, 0);
      tick;
      pc = exp;
      #1;
      chk("load_off", PC_load, 0);
      chk("next_hold", PC_next, exp);
      chk("stack_err", stack_err, err_m);
   endtask

   initial begin
      #2;
      do_reset;
      instr(OP_SEQ, 0, 0, 0, 2, 1, 0, 0);
      instr(OP_RET, 0, 0, 0, 0, 0, 0, 0);
      do_reset;
      pc = 16'h0010;
      instr(OP_BR, 1, 8'hFC, 0, 1, 0, 0, 0);
      pc = 16'h0010;
      instr(OP_BR, 0, 8'hFC, 0, 0, 2, 0, 0);
      pc = 16'hFFFF;
      instr(OP_SEQ, 0, 0, 0, 0, 0, 0, 0);
      pc = 16'h0100;
      instr(OP_CALL, 0, 0, 16'h0200, 1, 1, 0, 0);
      pc = 16'h0205;
      instr(OP_RET, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) instr(OP_CALL, 0, 0, 16'h1000 + 16'(i * 16), 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) instr(OP_RET, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) instr(OP_CALL, 0, 0, 16'h2000 + 16'(i * 16), 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) instr(OP_RET, 0, 0, 0, 1, 0, 0, 0);
      do_reset;
      pc = 16'h0042;
      instr(OP_HALT, 0, 0, 0, 0, 0, 20, 0);
      instr(OP_SEQ, 0, 0, 0, 0, 0, 0, 0);
      pc = 16'h0300;
      instr(OP_CALL, 0, 0, 16'h0400, 0, 0, 0, 0);
      instr(OP_SEQ, 0, 0, 0, 1, 0, 0, 1);
      instr(OP_SEQ, 0, 0, 0, 3, 0, 0, 2);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) pc = 16'($urandom);
         instr(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
               ($urandom_range(0, 29) == 0) ? $urandom_range(1, 2) : 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
